// File: rtl/sd_stream_reader_pkg.sv
// Shared types and sizes for the SD block stream reader and its ping-pong buffer.
package sd_stream_reader_pkg;

  localparam int unsigned BLOCK_BYTES = 512;
  localparam int unsigned ADDR_W      = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQUEST   = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_ABORT     = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

endpackage

// File: rtl/sd_pingpong_buffer.sv
// Two 512-byte halves in one simple dual-port RAM; the read port is registered.
module sd_pingpong_buffer
  import sd_stream_reader_pkg::*;
(
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W:0]   wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic [ADDR_W:0]   rd_addr_i,
  output logic [7:0]        rd_data_o
);

  logic [7:0] mem_q [2*BLOCK_BYTES];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Only the output register is reset so the array still maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sd_stream_reader.sv
// Sequences consecutive SD single-block reads into a ping-pong buffer and drains it as a byte stream.
module sd_stream_reader
  import sd_stream_reader_pkg::*;
#(
  parameter int unsigned Prefill = 2
) (
  input  logic        Clk_i,
  input  logic        nReset_i,
  input  logic        Start_i,
  input  logic        Stop_i,
  input  logic [31:0] Start_Block_i,
  input  logic [31:0] Block_Count_i,
  output logic        Active_o,
  output logic        Done_o,
  output logic        Error_o,
  output logic [31:0] SD_Block_o,
  output logic        SD_Read_o,
  input  logic        SD_Busy_i,
  input  logic [8:0]  SD_Address_i,
  input  logic [7:0]  SD_Data_i,
  input  logic        SD_Write_Enable_i,
  input  logic        SD_Card_Error_i,
  output logic [7:0]  Stream_Data_o,
  output logic        Stream_Valid_o,
  input  logic        Stream_Ready_i
);

  localparam logic [1:0]      PREFILL_CNT = 2'(Prefill);
  localparam logic [ADDR_W:0] PTR_ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q;
  logic [31:0]     block_q;
  logic [31:0]     count_q;
  logic [31:0]     read_count_q;
  logic            sd_read_q;
  logic            active_q;
  logic            done_q;
  logic            error_q;
  logic            valid_q;
  logic            stream_en_q;
  logic [1:0]      full_q;
  logic            fill_half_q;
  logic [ADDR_W:0] drain_ptr_q;

  logic [1:0]      full_cnt_d;
  logic            all_read_d;
  logic            stream_go_d;
  logic            xfer_d;
  logic            drain_half_d;
  logic            drain_last_d;
  logic [7:0]      rd_data;

  assign full_cnt_d   = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign all_read_d   = (count_q != 32'd0) && (read_count_q == count_q);
  // A short finite stream may never fill Prefill halves, so "all blocks read" also opens the tap.
  assign stream_go_d  = stream_en_q || (full_cnt_d >= PREFILL_CNT) || all_read_d;
  assign xfer_d       = valid_q && Stream_Ready_i;
  assign drain_half_d = drain_ptr_q[ADDR_W];
  assign drain_last_d = xfer_d && (&drain_ptr_q[ADDR_W-1:0]);

  sd_pingpong_buffer u_buffer (
    .clk_i     (Clk_i),
    .nreset_i  (nReset_i),
    .wr_en_i   (SD_Write_Enable_i),
    .wr_addr_i ({fill_half_q, SD_Address_i}),
    .wr_data_i (SD_Data_i),
    .rd_addr_i (drain_ptr_q),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge Clk_i) begin
    if (!nReset_i) begin
      state_q      <= ST_IDLE;
      block_q      <= '0;
      count_q      <= '0;
      read_count_q <= '0;
      sd_read_q    <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      valid_q      <= 1'b0;
      stream_en_q  <= 1'b0;
      full_q       <= '0;
      fill_half_q  <= 1'b0;
      drain_ptr_q  <= '0;
    end else begin
      done_q <= 1'b0;

      // Drain side: one byte per two cycles, the RAM address is always the drain pointer.
      if (active_q) begin
        if (stream_go_d) begin
          stream_en_q <= 1'b1;
        end
        if (xfer_d) begin
          valid_q     <= 1'b0;
          drain_ptr_q <= drain_ptr_q + PTR_ONE;
          if (drain_last_d) begin
            full_q[drain_half_d] <= 1'b0;
          end
        end else if (!valid_q && stream_go_d && full_q[drain_half_d]) begin
          valid_q <= 1'b1;
        end
      end

      if (state_q != ST_IDLE && state_q != ST_ERR && SD_Card_Error_i) begin
        state_q   <= ST_ERR;
        sd_read_q <= 1'b0;
        valid_q   <= 1'b0;
        active_q  <= 1'b0;
        error_q   <= 1'b1;
      end else if (state_q != ST_IDLE && state_q != ST_ERR && state_q != ST_ABORT && Stop_i) begin
        state_q <= ST_ABORT;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (Start_i) begin
              block_q      <= Start_Block_i;
              count_q      <= Block_Count_i;
              read_count_q <= '0;
              full_q       <= '0;
              fill_half_q  <= 1'b0;
              drain_ptr_q  <= '0;
              stream_en_q  <= 1'b0;
              valid_q      <= 1'b0;
              active_q     <= 1'b1;
              state_q      <= ST_REQUEST;
            end
          end
          ST_REQUEST: begin
            if (all_read_d) begin
              state_q <= ST_DRAIN;
            end else if (!full_q[fill_half_q]) begin
              sd_read_q <= 1'b1;
              state_q   <= ST_WAIT_ACK;
            end
          end
          ST_WAIT_ACK: begin
            if (SD_Busy_i) begin
              sd_read_q <= 1'b0;
              state_q   <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: begin
            if (!SD_Busy_i) begin
              full_q[fill_half_q] <= 1'b1;
              fill_half_q         <= ~fill_half_q;
              block_q             <= block_q + 32'd1;
              read_count_q        <= read_count_q + 32'd1;
              state_q             <= ST_REQUEST;
            end
          end
          ST_DRAIN: begin
            if (full_q == 2'b00) begin
              done_q   <= 1'b1;
              active_q <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
          ST_ABORT: begin
            // Let an outstanding read run to completion before releasing the SD block.
            if (sd_read_q && SD_Busy_i) begin
              sd_read_q <= 1'b0;
            end
            if (!sd_read_q && !SD_Busy_i) begin
              full_q   <= '0;
              valid_q  <= 1'b0;
              active_q <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
          ST_ERR: begin
            sd_read_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign Active_o       = active_q;
  assign Done_o         = done_q;
  assign Error_o        = error_q;
  assign SD_Block_o     = block_q;
  assign SD_Read_o      = sd_read_q;
  assign Stream_Data_o  = rd_data;
  assign Stream_Valid_o = valid_q;

endmodule

// File: tb/tb_sd_stream_reader.sv
// Directed bench: SD block model, stream consumer with scoreboard, one task per scenario.
module tb_sd_stream_reader;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] start_block = '0;
  logic [31:0] block_count = '0;
  logic        active, done, error, sd_read, s_valid;
  logic [31:0] sd_block;
  logic        sd_busy = 1'b0;
  logic [8:0]  sd_addr = '0;
  logic [7:0]  sd_data = '0;
  logic        sd_we = 1'b0;
  logic        sd_err = 1'b0;
  logic [7:0]  s_data;
  logic        s_ready = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          ready_mode = 1;
  int          done_cnt = 0;
  int          reads = 0;
  logic [31:0] blocks[$];
  logic [7:0]  got[$];
  logic        err_en = 1'b0;
  logic [31:0] err_block = '0;

  always #5 clk = ~clk;

  sd_stream_reader #(.Prefill(2)) dut (
    .Clk_i             (clk),
    .nReset_i          (nreset),
    .Start_i           (start),
    .Stop_i            (stop),
    .Start_Block_i     (start_block),
    .Block_Count_i     (block_count),
    .Active_o          (active),
    .Done_o            (done),
    .Error_o           (error),
    .SD_Block_o        (sd_block),
    .SD_Read_o         (sd_read),
    .SD_Busy_i         (sd_busy),
    .SD_Address_i      (sd_addr),
    .SD_Data_i         (sd_data),
    .SD_Write_Enable_i (sd_we),
    .SD_Card_Error_i   (sd_err),
    .Stream_Data_o     (s_data),
    .Stream_Valid_o    (s_valid),
    .Stream_Ready_i    (s_ready)
  );

  // SD block model: byte = (block + addr) & 0xFF, optional fatal error after the writes.
  initial begin
    logic [31:0] m_blk;
    forever begin
      @(negedge clk);
      if (sd_read && nreset) begin
        m_blk = sd_block;
        blocks.push_back(m_blk);
        reads++;
        @(negedge clk);
        @(negedge clk);
        sd_busy = 1'b1;
        for (int a = 0; a < 512; a++) begin
          sd_addr = a[8:0];
          sd_data = 8'(m_blk + 32'(a));
          sd_we   = 1'b1;
          @(negedge clk);
        end
        sd_we = 1'b0;
        if (err_en && m_blk == err_block) begin
          sd_err = 1'b1;
          @(negedge clk);
          sd_err = 1'b0;
        end
        @(negedge clk);
        sd_busy = 1'b0;
      end
    end
  end

  // Consumer: drives Ready, records accepted bytes, checks the valid gap and stall hold.
  initial begin
    logic       prev_xfer;
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_xfer = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       s_ready = 1'b0;
        1:       s_ready = 1'b1;
        default: s_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (done) begin
        done_cnt++;
        total++;
        if (active !== 1'b0) begin
          bad++;
          $display("FAIL done_active: active=%b with done, required 0", active);
        end
      end
      if (prev_xfer) begin
        total++;
        if (s_valid !== 1'b0) begin
          bad++;
          $display("FAIL valid_gap: valid=%b after transfer, required 0", s_valid);
        end
      end
      if (prev_stall && active) begin
        total++;
        if (s_valid !== 1'b1 || s_data !== prev_data) begin
          bad++;
          $display("FAIL stall_hold: valid=%b data=%02h, required 1/%02h", s_valid, s_data, prev_data);
        end
      end
      prev_xfer  = s_valid && s_ready;
      prev_stall = s_valid && !s_ready && active;
      prev_data  = s_data;
      if (prev_xfer) got.push_back(s_data);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_byte(input logic [31:0] sb, input int n);
    logic [31:0] blk;
    blk = sb + 32'(n / 512);
    return 8'(blk + 32'(n % 512));
  endfunction

  function automatic int byte_errors(input logic [31:0] sb);
    int e = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i] !== exp_byte(sb, i)) e++;
    end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    got.delete();
    blocks.delete();
    done_cnt = 0;
    reads = 0;
  endtask

  task automatic start_stream(input logic [31:0] b, input logic [31:0] c);
    @(negedge clk);
    start_block = b;
    block_count = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_inactive(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!active) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (active !== 1'b0)   begin bad++; $display("FAIL rst_active: got %b, required 0", active); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done: got %b, required 0", done); end
    total++; if (error !== 1'b0)    begin bad++; $display("FAIL rst_error: got %b, required 0", error); end
    total++; if (sd_read !== 1'b0)  begin bad++; $display("FAIL rst_sd_read: got %b, required 0", sd_read); end
    total++; if (sd_block !== 32'h0) begin bad++; $display("FAIL rst_sd_block: got %h, required 0", sd_block); end
    total++; if (s_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b, required 0", s_valid); end
    total++; if (s_data !== 8'h00)  begin bad++; $display("FAIL rst_data: got %h, required 00", s_data); end
    nreset = 1'b1;
    @(negedge clk);
    pulse_stop();
    repeat (3) @(negedge clk);
    total++; if (active !== 1'b0 || sd_read !== 1'b0) begin
      bad++; $display("FAIL idle_stop: active=%b sd_read=%b, required 0/0", active, sd_read);
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs();
    ready_mode = 1;
    start_stream(32'h100, 32'd3);
    total++; if (active !== 1'b1) begin bad++; $display("FAIL basic_active: got %b, required 1", active); end
    wait_inactive(6000, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: active still %b, required 0", active); end
    repeat (3) @(negedge clk);
    total++; if (blocks.size() != 3) begin bad++; $display("FAIL basic_nblocks: got %0d, required 3", blocks.size()); end
    for (int i = 0; i < blocks.size() && i < 3; i++) begin
      total++;
      if (blocks[i] !== 32'h100 + 32'(i)) begin
        bad++; $display("FAIL basic_block%0d: got %h, required %h", i, blocks[i], 32'h100 + 32'(i));
      end
    end
    total++; if (got.size() != 1536) begin bad++; $display("FAIL basic_nbytes: got %0d, required 1536", got.size()); end
    total++; if (byte_errors(32'h100) != 0) begin bad++; $display("FAIL basic_bytes: %0d wrong bytes, required 0", byte_errors(32'h100)); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done: got %0d pulses, required 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n_at_read;
    clear_logs();
    ready_mode = 0;
    start_stream(32'h200, 32'd3);
    repeat (3000) @(negedge clk);
    total++; if (reads != 2) begin bad++; $display("FAIL bp_reads: got %0d, required 2", reads); end
    total++; if (sd_read !== 1'b0) begin bad++; $display("FAIL bp_sd_read: got %b, required 0", sd_read); end
    total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b, required 1", s_valid); end
    total++; if (got.size() != 0) begin bad++; $display("FAIL bp_nbytes: got %0d, required 0", got.size()); end
    ready_mode = 1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (reads >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    n_at_read = got.size();
    total++; if (!ok) begin bad++; $display("FAIL bp_third_read: reads=%0d, required 3", reads); end
    total++; if (n_at_read < 512 || n_at_read > 515) begin
      bad++; $display("FAIL bp_read_after_drain: %0d bytes drained, required 512..515", n_at_read);
    end
    wait_inactive(4000, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout: active=%b, required 0", active); end
    repeat (3) @(negedge clk);
    total++; if (got.size() != 1536 || byte_errors(32'h200) != 0) begin
      bad++; $display("FAIL bp_bytes: %0d bytes %0d wrong, required 1536/0", got.size(), byte_errors(32'h200));
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_stop();
    bit ok;
    bit reread;
    bit early;
    clear_logs();
    ready_mode = 1;
    start_stream(32'h300, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (reads >= 3 && sd_busy && !sd_read) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) begin bad++; $display("FAIL stop_reach_wait_done: reads=%0d, required 3", reads); end
    pulse_stop();
    reread = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 1000 && sd_busy; i++) begin
      @(negedge clk);
      if (sd_read) reread = 1'b1;
      if (sd_busy && !active) early = 1'b1;
    end
    wait_inactive(5, ok);
    total++; if (reread) begin bad++; $display("FAIL stop_reread: SD_Read=1 seen, required 0"); end
    total++; if (early) begin bad++; $display("FAIL stop_early_idle: active=0 while busy, required 1"); end
    total++; if (!ok) begin bad++; $display("FAIL stop_idle: active=%b after busy fell, required 0", active); end
    repeat (20) @(negedge clk);
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL stop_valid: got %b, required 0", s_valid); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL stop_done: got %0d, required 0", done_cnt); end
    total++; if (reads != 3 || sd_read !== 1'b0) begin bad++; $display("FAIL stop_reads: reads=%0d sd_read=%b, required 3/0", reads, sd_read); end
    total++; if (got.size() == 0 || byte_errors(32'h300) != 0) begin
      bad++; $display("FAIL stop_bytes: %0d bytes %0d wrong, required >0/0", got.size(), byte_errors(32'h300));
    end
  endtask

  task automatic test_error();
    bit ok;
    clear_logs();
    ready_mode = 1;
    err_en = 1'b1;
    err_block = 32'h401;
    start_stream(32'h400, 32'd4);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (error) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) begin bad++; $display("FAIL err_set: error=%b, required 1", error); end
    total++; if (active !== 1'b0 || sd_read !== 1'b0 || s_valid !== 1'b0) begin
      bad++; $display("FAIL err_outputs: active=%b sd_read=%b valid=%b, required 0/0/0", active, sd_read, s_valid);
    end
    start_stream(32'h500, 32'd1);
    repeat (10) @(negedge clk);
    total++; if (active !== 1'b0 || sd_read !== 1'b0 || error !== 1'b1) begin
      bad++; $display("FAIL err_sticky: active=%b sd_read=%b error=%b, required 0/0/1", active, sd_read, error);
    end
    for (int i = 0; i < 1000 && sd_busy; i++) @(negedge clk);
    err_en = 1'b0;
    do_reset();
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b, required 0", error); end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_logs();
    ready_mode = 1;
    start_stream(32'hFFFF_FFFF, 32'd2);
    wait_inactive(4000, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: active=%b, required 0", active); end
    repeat (3) @(negedge clk);
    total++; if (blocks.size() != 2) begin bad++; $display("FAIL wrap_nblocks: got %0d, required 2", blocks.size()); end
    if (blocks.size() == 2) begin
      total++; if (blocks[0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_block0: got %h, required ffffffff", blocks[0]); end
      total++; if (blocks[1] !== 32'h0) begin bad++; $display("FAIL wrap_block1: got %h, required 00000000", blocks[1]); end
    end
    total++; if (got.size() != 1024 || byte_errors(32'hFFFF_FFFF) != 0) begin
      bad++; $display("FAIL wrap_bytes: %0d bytes %0d wrong, required 1024/0", got.size(), byte_errors(32'hFFFF_FFFF));
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL wrap_done: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_endless();
    bit ok;
    clear_logs();
    ready_mode = 2;
    start_stream(32'h500, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (reads >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) begin bad++; $display("FAIL endless_reads: got %0d, required 10", reads); end
    pulse_stop();
    wait_inactive(2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL endless_abort: active=%b, required 0", active); end
    repeat (5) @(negedge clk);
    total++; if (got.size() < 4096 || byte_errors(32'h500) != 0) begin
      bad++; $display("FAIL endless_bytes: %0d bytes %0d wrong, required >=4096/0", got.size(), byte_errors(32'h500));
    end
    total++; if (s_valid !== 1'b0 || sd_read !== 1'b0 || done_cnt != 0) begin
      bad++; $display("FAIL endless_clean: valid=%b sd_read=%b done=%0d, required 0/0/0", s_valid, sd_read, done_cnt);
    end
    ready_mode = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stop();
    test_error();
    test_wrap();
    test_endless();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
